// File: rtl/sync_updown_cnt.sv
// ---------------------------------------------------------------------------
// sync_updown_cnt
//
// Fully synchronous up/down counter with programmable modulus, count enable,
// parallel load, direction control, a combinational cascade carry and a
// registered wrap pulse.
//
// Every state bit updates on the same rising edge. Q can therefore be
// decoded directly without glitches.
//
// Optional feature, selected by macro SYNC_UPDOWN_CNT_SAT_EN:
//   defined   - saturating mode. The counter holds at the bound instead of
//               wrapping. SAT flags an attempted step past a bound, and WRAP
//               is constant 0.
//   undefined - wrapping mode (default). SAT is constant 0.
//
// Parameters
//   WIDTH    counter width in bits (1..16)
//   MODULUS  count range 0..MODULUS-1 (2..2^WIDTH)
//
// Ports
//   CLK   in   rising-edge clock
//   RST   in   synchronous active-high reset (Q, WRAP, SAT -> 0)
//   EN    in   count enable
//   UP    in   direction: 1 = up, 0 = down
//   LOAD  in   parallel load strobe (beats EN; out-of-range D loads 0)
//   D     in   parallel load value
//   Q     out  registered count value
//   TC    out  combinational terminal count, drives EN of the next stage
//   WRAP  out  registered one-cycle pulse after a wrapping step
//   SAT   out  registered "held at a bound" flag (saturating mode only)
// ---------------------------------------------------------------------------
module sync_updown_cnt #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP,
  output logic             SAT
);

`ifdef SYNC_UPDOWN_CNT_SAT_EN
  localparam bit SAT_MODE = 1'b1;
`else
  localparam bit SAT_MODE = 1'b0;
`endif

  // Compares are done one bit wider than the counter. As a result,
  // MODULUS = 2^WIDTH is representable and never overflows.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_Q = MAX_W[WIDTH-1:0];

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;

  logic at_top;
  logic at_bot;
  logic at_bound;
  logic load_ok;

  assign at_top   = ({1'b0, q_q} == MAX_W);
  assign at_bot   = (q_q == '0);
  assign at_bound = UP ? at_top : at_bot;
  assign load_ok  = ({1'b0, D} < MOD_W);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    // SAT persists while the counter idles at a bound. In wrapping mode it
    // never gets set.
    sat_d  = SAT_MODE ? sat_q : 1'b0;

    if (LOAD) begin
      q_d   = load_ok ? D : '0;
      sat_d = 1'b0;
    end else if (EN) begin
      sat_d = 1'b0;
      if (at_bound) begin
        if (SAT_MODE) begin
          // Hold at the bound. Flag that a step was lost.
          sat_d = 1'b1;
        end else begin
          q_d    = UP ? '0 : MAX_Q;
          wrap_d = 1'b1;
        end
      end else begin
        q_d = UP ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  // Combinational carry lets a chain of counters advance on a single edge.
  // It is masked by LOAD and RST because neither of those counts.
  assign TC   = EN & ~LOAD & ~RST & at_bound;
  assign Q    = q_q;
  assign WRAP = wrap_q;
  assign SAT  = sat_q;

endmodule

// File: tb/tb_sync_updown_cnt.sv
module tb_sync_updown_cnt;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [3:0] d = 4'd0;
  logic [3:0] q;
  logic       tc, wrap, sat;

  // Cascade pair: the low stage carry enables the high stage.
  logic       c_rst = 1'b0, c_en = 1'b0;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_sat, hi_sat;

  always #5 clk = ~clk;

  sync_updown_cnt #(.WIDTH(4), .MODULUS(10)) dut (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load), .D(d),
    .Q(q), .TC(tc), .WRAP(wrap), .SAT(sat)
  );

  sync_updown_cnt #(.WIDTH(4), .MODULUS(10)) u_lo (
    .CLK(clk), .RST(c_rst), .EN(c_en), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
    .Q(lo_q), .TC(lo_tc), .WRAP(lo_wrap), .SAT(lo_sat)
  );

  sync_updown_cnt #(.WIDTH(4), .MODULUS(10)) u_hi (
    .CLK(clk), .RST(c_rst), .EN(lo_tc), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
    .Q(hi_q), .TC(hi_tc), .WRAP(hi_wrap), .SAT(hi_sat)
  );

  typedef struct {
    logic       rst, load, en, up;
    logic [3:0] d;
    logic [3:0] q;
    logic       wrap, sat, tc;
  } vec_t;

  typedef struct {
    logic [6:0] val;
    logic       wrap, sat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  function automatic void add(input logic r, input logic l, input logic e,
                              input logic u, input logic [3:0] dv,
                              input logic [3:0] eq, input logic ew,
                              input logic es, input logic et);
    vec_t v;
    v.rst = r; v.load = l; v.en = e; v.up = u; v.d = dv;
    v.q = eq; v.wrap = ew; v.sat = es; v.tc = et;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, expv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;

    // Vector fields: rst, load, en, up, d -> q, wrap, sat after the edge,
    // and tc with these inputs applied before the edge.
    add(1, 0, 0, 1, 0,  0, 0, 0, 0);            // reset state
`ifndef SYNC_UPDOWN_CNT_SAT_EN
    for (int i = 0; i < 12; i++) begin          // up-count 0..9,0,1
      int cur;
      cur = i % 10;
      add(0, 0, 1, 1, 0, 4'((cur + 1) % 10), cur == 9, 0, cur == 9);
    end
    add(0, 0, 1, 0, 0,  1, 0, 0, 0);            // down from 2
    add(0, 0, 1, 0, 0,  0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  9, 1, 0, 1);            // 0 -> 9 wraps
    add(0, 0, 1, 0, 0,  8, 0, 0, 0);
    add(0, 1, 1, 1, 7,  7, 0, 0, 0);            // load beats enable
    add(0, 1, 0, 1, 12, 0, 0, 0, 0);            // D >= MODULUS
    add(0, 1, 0, 1, 10, 0, 0, 0, 0);            // D == MODULUS
    add(0, 0, 0, 1, 5,  0, 0, 0, 0);            // idle holds
    add(1, 1, 1, 1, 5,  0, 0, 0, 0);            // reset beats load
    add(0, 1, 0, 1, 5,  5, 0, 0, 0);
    add(0, 0, 1, 1, 0,  6, 0, 0, 0);            // 5 up -> 6
    add(0, 0, 1, 0, 0,  5, 0, 0, 0);            // direction flip -> 5
    add(0, 1, 0, 1, 9,  9, 0, 0, 0);
    add(1, 0, 1, 1, 0,  0, 0, 0, 0);            // reset at 9 with EN
    add(0, 1, 0, 1, 9,  9, 0, 0, 0);
    add(0, 0, 1, 1, 0,  0, 1, 0, 1);            // wrap pending
    add(1, 0, 1, 1, 0,  0, 0, 0, 0);            // reset clears WRAP
    add(0, 0, 1, 0, 0,  9, 1, 0, 1);
    add(0, 0, 0, 1, 0,  9, 0, 0, 0);            // WRAP lasts one cycle
`else
    add(0, 1, 0, 1, 8,  8, 0, 0, 0);
    add(0, 0, 1, 1, 0,  9, 0, 0, 0);            // 8 -> 9
    add(0, 0, 1, 1, 0,  9, 0, 1, 1);            // held at top
    add(0, 0, 1, 1, 0,  9, 0, 1, 1);
    add(0, 0, 1, 0, 0,  8, 0, 0, 0);            // step away clears SAT
    add(0, 1, 0, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  0, 0, 1, 1);            // held at bottom
    add(0, 0, 1, 1, 0,  1, 0, 0, 0);
    add(0, 1, 0, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  0, 0, 1, 1);
    add(0, 1, 1, 0, 3,  3, 0, 0, 0);            // load clears SAT
    add(0, 1, 0, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  0, 0, 1, 1);
    add(1, 0, 1, 0, 0,  0, 0, 0, 0);            // reset clears SAT
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; load = vecs[i].load; en = vecs[i].en;
      up = vecs[i].up;   d = vecs[i].d;
      #1;
      check("tc", i, 32'(tc), 32'(vecs[i].tc));
      e.val = 7'(vecs[i].q); e.wrap = vecs[i].wrap; e.sat = vecs[i].sat;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("q", i, 32'(q), 32'(e.val));
      check("wrap", i, 32'(wrap), 32'(e.wrap));
      check("sat", i, 32'(sat), 32'(e.sat));
    end
    @(negedge clk);
    rst = 1'b0; load = 1'b0; en = 1'b0;

`ifndef SYNC_UPDOWN_CNT_SAT_EN
    // Cascade: 100 enabled cycles from reset, combined count 00..99..00.
    c_rst = 1'b1; c_en = 1'b1;
    @(posedge clk);
    #1;
    check("casc_rst", 0, 32'({hi_q, lo_q}), 32'd0);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      c_rst = 1'b0;
      #1;
      check("casc_tc", k, 32'(lo_tc), 32'(((k - 1) % 10) == 9));
      e.val = 7'(k % 100); e.wrap = (k % 10) == 0; e.sat = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("casc_cnt", k, 32'(hi_q) * 10 + 32'(lo_q), 32'(e.val));
      check("casc_lo_wrap", k, 32'(lo_wrap), 32'(e.wrap));
    end
    @(negedge clk);
    c_en = 1'b0;
`endif

    check("sb_empty", 0, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
